// File: rtl/serial_link_physical_tx_mc_pkg.sv
// Shared types for the multi-channel serial link TX physical layer.
// Internal phase/config width is fixed so the shadow struct can live here.
package serial_link_physical_tx_mc_pkg;

  localparam int unsigned CfgW = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } phy_tx_state_e;

  typedef struct packed {
    logic [CfgW-1:0] div;
    logic [CfgW-1:0] half;
    logic [CfgW-1:0] shift_start;
    logic [CfgW-1:0] shift_end;
    logic            ddr;
  } phy_cfg_t;

  // Divisors of 0 or 1 cannot produce two clock phases, so they run as 2.
  function automatic logic [CfgW-1:0] clamp_div(input logic [CfgW-1:0] div);
    return (div < CfgW'(2)) ? CfgW'(2) : div;
  endfunction

endpackage

// File: rtl/serial_link_physical_tx_mc_if.sv
// Beat handshake between the data-link layer (master) and the TX PHY (slave).
interface serial_link_physical_tx_mc_if #(
  parameter int unsigned NumChannels = 1,
  parameter int unsigned BeatW       = 16
);
  logic [NumChannels*BeatW-1:0] data_out;
  logic                         data_out_valid;
  logic                         data_out_ready;

  modport master (output data_out, output data_out_valid, input data_out_ready);
  modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/serial_link_physical_tx_mc_clk_gen.sv
// Beat phase counter and forwarded-clock flop, shared by all channels.
// The clock is only ever set or cleared, so its polarity cannot drift.
module serial_link_phy_clk_gen
  import serial_link_physical_tx_mc_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     run_i,
  input  logic     run_next_i,
  input  phy_cfg_t cfg_i,
  output logic     wrap_o,
  output logic     low_half_o,
  output logic     clk_o
);

  logic [CfgW-1:0] cnt_q, cnt_d;
  logic            clk_q, clk_d;

  assign wrap_o     = (cnt_q == cfg_i.div - CfgW'(1));
  assign low_half_o = (cnt_q < cfg_i.half);
  assign clk_o      = clk_q;

  always_comb begin
    cnt_d = cnt_q + CfgW'(1);
    if (!run_i || wrap_o) cnt_d = '0;

    // End beats start so equal settings leave the clock high; a stop always parks it high.
    clk_d = clk_q;
    if (!run_i || !run_next_i)              clk_d = 1'b1;
    else if (cnt_q == cfg_i.shift_end)      clk_d = 1'b1;
    else if (cnt_q == cfg_i.shift_start)    clk_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/serial_link_physical_tx_mc.sv
// Multi-channel source-synchronous TX PHY: beat register, config shadows,
// per-channel DDR/SDR lane mux and gated forwarded clocks.
//   state | meaning
//   IDLE  | no beat on the wire; clocks high, lanes low, config shadows track inputs
//   RUN   | driving a beat; config frozen, counter walks 0..div-1
module serial_link_physical_tx_mc
  import serial_link_physical_tx_mc_pkg::*;
#(
  parameter  int unsigned NumChannels = 1,
  parameter  int unsigned NumLanes    = 8,
  parameter  int unsigned MaxClkDiv   = 32,
  parameter  bit          EnDdr       = 1'b1,
  localparam int unsigned BeatW       = NumLanes * (EnDdr ? 2 : 1),
  localparam int unsigned CntW        = $clog2(MaxClkDiv) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [CntW-1:0]                 clk_div_i,
  input  logic [CntW-1:0]                 clk_shift_start_i,
  input  logic [CntW-1:0]                 clk_shift_end_i,
  input  logic                            ddr_mode_i,
  input  logic [NumChannels-1:0]          chan_en_i,
  input  logic                            train_en_i,
  input  logic [NumLanes-1:0]             train_pattern_i,
  serial_link_physical_tx_mc_if.slave     bus,
  output logic                            busy_o,
  output logic [NumChannels-1:0]          ddr_rcv_clk_o,
  output logic [NumChannels*NumLanes-1:0] ddr_o
);

  phy_tx_state_e                state_q, state_d;
  phy_cfg_t                     cfg_q, cfg_d, cfg_live;
  logic [NumChannels-1:0]       chan_en_q, chan_en_d;
  logic [NumChannels*BeatW-1:0] beat_q, beat_d, train_beat;
  logic                         bnd, ready, wrap, low_half, fwd_clk, run_q, run_d;

  always_comb begin
    cfg_live             = '0;
    cfg_live.div         = clamp_div(CfgW'(clk_div_i));
    cfg_live.half        = cfg_live.div >> 1;
    cfg_live.shift_start = CfgW'(clk_shift_start_i);
    cfg_live.shift_end   = CfgW'(clk_shift_end_i);
    cfg_live.ddr         = ddr_mode_i & EnDdr;
  end

  assign cfg_d     = (state_q == IDLE) ? cfg_live  : cfg_q;
  assign chan_en_d = (state_q == IDLE) ? chan_en_i : chan_en_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_train
    if (EnDdr) begin : g_ddr
      assign train_beat[c*BeatW +: BeatW] = cfg_d.ddr ? {~train_pattern_i, train_pattern_i}
                                                      : {{NumLanes{1'b0}}, train_pattern_i};
    end else begin : g_sdr
      assign train_beat[c*BeatW +: BeatW] = train_pattern_i;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    bnd     = (state_q == IDLE) || wrap;
    // Reset term keeps the upstream from seeing a handshake while flops are held.
    ready   = bnd && !train_en_i && rst_ni;
    if (bnd) begin
      if (train_en_i) begin
        beat_d  = train_beat;
        state_d = RUN;
      end else if (bus.data_out_valid && ready) begin
        beat_d  = bus.data_out;
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cfg_q     <= '{div: CfgW'(2), half: CfgW'(1), shift_start: '0, shift_end: '0, ddr: 1'b0};
      chan_en_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      chan_en_q <= chan_en_d;
      beat_q    <= beat_d;
    end
  end

  assign run_q               = (state_q == RUN);
  assign run_d               = (state_d == RUN);
  assign busy_o              = run_q;
  assign bus.data_out_ready  = ready;

  serial_link_phy_clk_gen u_clk_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .run_i      (run_q),
    .run_next_i (run_d),
    .cfg_i      (cfg_q),
    .wrap_o     (wrap),
    .low_half_o (low_half),
    .clk_o      (fwd_clk)
  );

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [BeatW-1:0]    chunk;
    logic [NumLanes-1:0] lanes;

    assign chunk = beat_q[c*BeatW +: BeatW];

    if (EnDdr) begin : g_ddr
      assign lanes = (cfg_q.ddr && !low_half) ? chunk[2*NumLanes-1:NumLanes] : chunk[NumLanes-1:0];
    end else begin : g_sdr
      assign lanes = chunk[NumLanes-1:0];
    end

    assign ddr_o[c*NumLanes +: NumLanes] = (run_q && chan_en_q[c]) ? lanes : '0;
    assign ddr_rcv_clk_o[c]              = fwd_clk | ~chan_en_q[c];
  end

endmodule

// File: tb/tb_serial_link_physical_tx_mc.sv
// Directed plus randomized bench for the 2-channel TX PHY against a
// beat-level reference model (phase index, latched config, beat contents).
module tb_serial_link_physical_tx_mc;

  localparam int NC = 2;
  localparam int NL = 8;
  localparam int BW = 16;
  localparam int CW = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [CW-1:0] clk_div, s_start, s_end;
  logic          ddr_mode, train_en;
  logic [NC-1:0] chan_en;
  logic [NL-1:0] train_pat;
  logic          busy;
  logic [NC-1:0] rcv_clk;
  logic [NC*NL-1:0] ddr_o;

  serial_link_physical_tx_mc_if #(.NumChannels(NC), .BeatW(BW)) bus ();

  serial_link_physical_tx_mc #(
    .NumChannels (NC),
    .NumLanes    (NL),
    .MaxClkDiv   (32),
    .EnDdr       (1'b1)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clk_div_i         (clk_div),
    .clk_shift_start_i (s_start),
    .clk_shift_end_i   (s_end),
    .ddr_mode_i        (ddr_mode),
    .chan_en_i         (chan_en),
    .train_en_i        (train_en),
    .train_pattern_i   (train_pat),
    .bus               (bus),
    .busy_o            (busy),
    .ddr_rcv_clk_o     (rcv_clk),
    .ddr_o             (ddr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // reference model: beat-level view of the link
  bit        m_run, m_ddr, m_clk, m_acc, rnd_data;
  int        m_k, m_div, m_half, m_s, m_e;
  bit [1:0]  m_en;
  bit [31:0] m_beat;
  logic [15:0] obs_ddr;
  logic [1:0]  obs_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_lanes(input int c);
    logic [15:0] b;
    b = m_beat[c*16 +: 16];
    if (!m_run || !m_en[c]) return 8'h00;
    if (m_ddr && m_k >= m_half) return b[15:8];
    return b[7:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_clk = 1; m_k = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
  task automatic tick();
    logic [15:0] e_ddr;
    logic [1:0]  e_clk;
    bit bnd, e_rdy, nclk, go;
    @(negedge clk_i); #1;
    e_ddr = {exp_lanes(1), exp_lanes(0)};
    for (int c = 0; c < NC; c++) e_clk[c] = m_en[c] ? m_clk : 1'b1;
    if (!m_run) e_clk = 2'b11;
    bnd   = !m_run || (m_k == m_div - 1);
    e_rdy = bnd && !train_en;
    obs_ddr = ddr_o;
    obs_clk = rcv_clk;
    chk("ddr_o", ddr_o, e_ddr);
    chk("rcv_clk", rcv_clk, e_clk);
    chk("busy", busy, m_run);
    chk("ready", bus.data_out_ready, e_rdy);

    nclk = m_clk;
    if (m_run) nclk = (m_k == m_e) ? 1'b1 : (m_k == m_s) ? 1'b0 : m_clk;
    if (!m_run) begin
      m_div  = (clk_div < 2) ? 2 : int'(clk_div);
      m_half = m_div / 2;
      m_s    = int'(s_start);
      m_e    = int'(s_end);
      m_ddr  = ddr_mode;
      m_en   = chan_en;
    end
    m_acc = 0;
    go    = 0;
    if (bnd) begin
      if (train_en) begin
        m_beat = {2{m_ddr ? {~train_pat, train_pat} : {8'h00, train_pat}}};
        go = 1;
      end else if (bus.data_out_valid) begin
        m_beat = bus.data_out;
        go = 1;
        m_acc = 1;
      end
      m_clk = (go && m_run) ? nclk : 1'b1;
      m_run = go;
      m_k   = 0;
    end else begin
      m_k++;
      m_clk = nclk;
    end
    @(posedge clk_i); #1;
    if (m_acc && rnd_data) bus.data_out = $urandom;
  endtask

  task automatic set_cfg(input int div, input int st, input int en, input bit ddr, input bit [1:0] ce);
    clk_div = CW'(div); s_start = CW'(st); s_end = CW'(en); ddr_mode = ddr; chan_en = ce;
  endtask

  logic [7:0] exp_byte [4];
  logic       exp_bit  [4];

  initial begin
    rst_ni = 0;
    set_cfg(4, 0, 2, 1, 2'b01);
    train_en = 0; train_pat = 8'h0F; rnd_data = 0;
    bus.data_out = '0;
    bus.data_out_valid = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rst_ddr_o", ddr_o, 16'h0);
    chk("rst_clk", rcv_clk, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.data_out_ready, 1'b0);
    bus.data_out_valid = 0;
    rst_ni = 1;
    model_reset();
    @(posedge clk_i); #1;

    // single DDR beat, 0xA55A on channel 0
    bus.data_out = {16'h1234, 16'hA55A};
    bus.data_out_valid = 1;
    tick();
    bus.data_out_valid = 0;
    exp_byte = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
    exp_bit  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_lane", obs_ddr[7:0], exp_byte[i]);
      chk("t1_clk", obs_clk[0], exp_bit[i]);
    end
    repeat (3) tick();
    chk("t1_idle_busy", busy, 1'b0);

    // three back-to-back beats then stop
    rnd_data = 1;
    bus.data_out = $urandom;
    bus.data_out_valid = 1;
    tick();
    repeat (7) tick();
    bus.data_out_valid = 0;
    repeat (8) tick();

    // SDR, div=2, single beat 0x3C
    set_cfg(2, 0, 1, 0, 2'b01);
    rnd_data = 0;
    bus.data_out = {16'h00FF, 16'hAB3C};
    bus.data_out_valid = 1;
    tick();
    bus.data_out_valid = 0;
    exp_byte = '{8'h3C, 8'h3C, 8'h00, 8'h00};
    exp_bit  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_lane", obs_ddr[7:0], exp_byte[i]);
      chk("t3_clk", obs_clk[0], exp_bit[i]);
    end

    // training overrides valid data, then data resumes
    set_cfg(4, 0, 2, 1, 2'b11);
    rnd_data = 1;
    train_en = 1;
    bus.data_out = $urandom;
    bus.data_out_valid = 1;
    tick();
    exp_byte = '{8'h0F, 8'h0F, 8'hF0, 8'hF0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_lane", obs_ddr[7:0], exp_byte[i]);
    end
    repeat (2) tick();
    train_en = 0;
    repeat (12) tick();
    bus.data_out_valid = 0;
    repeat (6) tick();

    // only channel 1 enabled; enable changes in RUN are ignored
    set_cfg(3, 1, 2, 1, 2'b10);
    bus.data_out_valid = 1;
    tick();
    chan_en = 2'b01;
    repeat (8) tick();
    chan_en = 2'b11;
    repeat (4) tick();
    bus.data_out_valid = 0;
    repeat (5) tick();

    // div=0 behaves as 2, start=end keeps clock high, reset mid-beat
    set_cfg(0, 1, 1, 1, 2'b11);
    bus.data_out_valid = 1;
    repeat (7) tick();
    set_cfg(5, 1, 3, 1, 2'b11);
    tick();
    tick();
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_ddr_o", ddr_o, 16'h0);
    chk("mid_rst_clk", rcv_clk, 2'b11);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", bus.data_out_ready, 1'b0);
    @(posedge clk_i); #1;
    chk("in_rst_busy", busy, 1'b0);
    chk("in_rst_ddr_o", ddr_o, 16'h0);
    rst_ni = 1;
    model_reset();
    repeat (12) tick();

    // randomized traffic and configuration
    for (int n = 0; n < 300; n++) begin
      bus.data_out_valid = ($urandom_range(0, 3) != 0);
      train_en  = ($urandom_range(0, 11) == 0);
      train_pat = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 8),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      tick();
    end
    bus.data_out_valid = 0;
    train_en = 0;
    repeat (12) tick();
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
